// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: writeback stage behind the functional units.
// Each FU result channel is buffered in a DEPTH-entry FIFO, and up to N_CDB
// FIFO heads per cycle are granted onto registered CDB broadcast ports.
// Results younger than a mispredicted branch are squashed in flight.
// Build option: define WB_AGE_PRIO_EN to grant the oldest heads first (by ROB
// age) instead of the default round-robin scan.
module fu_wb_arbiter #(
    parameter int N_CH   = 3,
    parameter int N_CDB  = 2,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [N_CH*TAG_W-1:0]   in_rob_tag,
    input  logic [N_CH*PREG_W-1:0]  in_pd,
    input  logic [N_CH-1:0]         in_we,
    input  logic [N_CH*DATA_W-1:0]  in_data,
    input  logic [TAG_W-1:0]        rob_head,
    input  logic                    mispredict,
    input  logic [TAG_W-1:0]        mispredict_tag,
    output logic [N_CDB-1:0]        cdb_valid,
    output logic [N_CDB*TAG_W-1:0]  cdb_rob_tag,
    output logic [N_CDB*PREG_W-1:0] cdb_pd,
    output logic [N_CDB-1:0]        cdb_we,
    output logic [N_CDB*DATA_W-1:0] cdb_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PREG_W-1:0] pd;
        logic              we;
        logic [DATA_W-1:0] data;
    } entry_t;

    // FIFO storage: entry 0 is always the head, so compaction is a shift
    entry_t           q_ent  [N_CH][DEPTH];
    entry_t           n_ent  [N_CH][DEPTH];
    logic [CNT_W-1:0] q_cnt  [N_CH];
    logic [CNT_W-1:0] n_cnt  [N_CH];
    entry_t           in_ent [N_CH];
    logic [CNT_W-1:0] wr_cnt;

    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  grant;
    logic [N_CDB-1:0] port_vld;
    logic [CH_W-1:0]  port_ch [N_CDB];
    logic             found;
    logic [CH_W-1:0]  best;

    logic [N_CDB-1:0]        cdb_valid_d;
    logic [N_CDB*TAG_W-1:0]  cdb_tag_d;
    logic [N_CDB*PREG_W-1:0] cdb_pd_d;
    logic [N_CDB-1:0]        cdb_we_d;
    logic [N_CDB*DATA_W-1:0] cdb_data_d;

    // Modulo age compare: the tag furthest from rob_head is the youngest
    function automatic logic is_younger(input logic [TAG_W-1:0] t,
                                        input logic [TAG_W-1:0] head,
                                        input logic [TAG_W-1:0] br);
        logic [TAG_W-1:0] age_t;
        logic [TAG_W-1:0] age_b;
        age_t = t - head;
        age_b = br - head;
        return age_t > age_b;
    endfunction

    // Unpack per-channel inputs and report FIFO space
    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            in_ent[c].tag  = in_rob_tag[c*TAG_W +: TAG_W];
            in_ent[c].pd   = in_pd[c*PREG_W +: PREG_W];
            in_ent[c].we   = in_we[c];
            in_ent[c].data = in_data[c*DATA_W +: DATA_W];
            in_ready[c]    = (q_cnt[c] != CNT_W'(DEPTH));
        end
    end

    // A head competes only if present and not squashed at this edge
    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            elig[c] = (q_cnt[c] != '0) &&
                      !(mispredict && is_younger(q_ent[c][0].tag, rob_head, mispredict_tag));
        end
    end

`ifdef WB_AGE_PRIO_EN
    logic [TAG_W-1:0] best_age;
    logic [TAG_W-1:0] cur_age;

    // Oldest-first grant: each port takes the oldest remaining head, ties to lower channel
    always_comb begin
        grant    = '0;
        port_vld = '0;
        found    = 1'b0;
        best     = '0;
        best_age = '0;
        cur_age  = '0;
        for (int unsigned p = 0; p < N_CDB; p++) begin
            port_ch[p] = '0;
        end
        for (int unsigned p = 0; p < N_CDB; p++) begin
            found    = 1'b0;
            best     = '0;
            best_age = '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                cur_age = q_ent[c][0].tag - rob_head;
                if (elig[c] && !grant[c] && (!found || (cur_age < best_age))) begin
                    found    = 1'b1;
                    best     = CH_W'(c);
                    best_age = cur_age;
                end
            end
            if (found) begin
                grant[best] = 1'b1;
                port_vld[p] = 1'b1;
                port_ch[p]  = best;
            end
        end
    end
`else
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_next;
    logic [CH_W-1:0] scan_ch;

    // Round-robin grant: each port takes the next ungranted head in scan order from rr_ptr
    always_comb begin
        grant    = '0;
        port_vld = '0;
        found    = 1'b0;
        best     = '0;
        scan_ch  = '0;
        rr_next  = rr_ptr;
        for (int unsigned p = 0; p < N_CDB; p++) begin
            port_ch[p] = '0;
        end
        for (int unsigned p = 0; p < N_CDB; p++) begin
            found = 1'b0;
            best  = '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                scan_ch = CH_W'((32'(rr_ptr) + k) % 32'(N_CH));
                if (!found && elig[scan_ch] && !grant[scan_ch]) begin
                    found = 1'b1;
                    best  = scan_ch;
                end
            end
            if (found) begin
                grant[best] = 1'b1;
                port_vld[p] = 1'b1;
                port_ch[p]  = best;
                rr_next     = CH_W'((32'(best) + 1) % 32'(N_CH));
            end
        end
    end

    // Round-robin pointer advances past the last granted channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end
`endif

    // Next FIFO contents: drop popped head and squashed entries, shift survivors
    // down, then append the accepted input unless it is itself squashed
    always_comb begin
        wr_cnt = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            wr_cnt = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                n_ent[c][i] = q_ent[c][i];
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((i < 32'(q_cnt[c])) && !((i == 0) && grant[c]) &&
                    !(mispredict && is_younger(q_ent[c][i].tag, rob_head, mispredict_tag))) begin
                    n_ent[c][wr_cnt[IDX_W-1:0]] = q_ent[c][i];
                    wr_cnt = wr_cnt + 1'b1;
                end
            end
            if (in_valid[c] && in_ready[c] &&
                !(mispredict && is_younger(in_ent[c].tag, rob_head, mispredict_tag))) begin
                n_ent[c][wr_cnt[IDX_W-1:0]] = in_ent[c];
                wr_cnt = wr_cnt + 1'b1;
            end
            n_cnt[c] = wr_cnt;
        end
    end

    // FIFO state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                q_cnt[c] <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    q_ent[c][i] <= '0;
                end
            end
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                q_cnt[c] <= n_cnt[c];
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    q_ent[c][i] <= n_ent[c][i];
                end
            end
        end
    end

    // CDB port contents: granted head fields, zero on unused ports
    always_comb begin
        cdb_valid_d = '0;
        cdb_tag_d   = '0;
        cdb_pd_d    = '0;
        cdb_we_d    = '0;
        cdb_data_d  = '0;
        for (int unsigned p = 0; p < N_CDB; p++) begin
            if (port_vld[p]) begin
                cdb_valid_d[p]                 = 1'b1;
                cdb_tag_d[p*TAG_W +: TAG_W]    = q_ent[port_ch[p]][0].tag;
                cdb_pd_d[p*PREG_W +: PREG_W]   = q_ent[port_ch[p]][0].pd;
                cdb_we_d[p]                    = q_ent[port_ch[p]][0].we;
                cdb_data_d[p*DATA_W +: DATA_W] = q_ent[port_ch[p]][0].data;
            end
        end
    end

    // Registered CDB outputs; a pulse lasts one cycle since the grant pops the head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid   <= '0;
            cdb_rob_tag <= '0;
            cdb_pd      <= '0;
            cdb_we      <= '0;
            cdb_data    <= '0;
        end else begin
            cdb_valid   <= cdb_valid_d;
            cdb_rob_tag <= cdb_tag_d;
            cdb_pd      <= cdb_pd_d;
            cdb_we      <= cdb_we_d;
            cdb_data    <= cdb_data_d;
        end
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed testbench for fu_wb_arbiter with default parameters
// (N_CH=3, N_CDB=2, DEPTH=4, DATA_W=32, TAG_W=5, PREG_W=7).
module tb_fu_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [14:0] in_rob_tag;
    logic [20:0] in_pd;
    logic [2:0]  in_we;
    logic [95:0] in_data;
    logic [4:0]  rob_head;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_rob_tag;
    logic [13:0] cdb_pd;
    logic [1:0]  cdb_we;
    logic [63:0] cdb_data;

    int total = 0;
    int bad   = 0;

    fu_wb_arbiter #(
        .N_CH(3), .N_CDB(2), .DEPTH(4), .DATA_W(32), .TAG_W(5), .PREG_W(7)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rob_tag(in_rob_tag),
        .in_pd(in_pd), .in_we(in_we), .in_data(in_data),
        .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_pd(cdb_pd),
        .cdb_we(cdb_we), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid   = '0;
        in_rob_tag = '0;
        in_pd      = '0;
        in_we      = '0;
        in_data    = '0;
    endtask

    task automatic set_ch(input int c, input logic [4:0] tag, input logic [6:0] pd,
                          input logic we, input logic [31:0] data);
        in_valid[c]          = 1'b1;
        in_rob_tag[c*5 +: 5] = tag;
        in_pd[c*7 +: 7]      = pd;
        in_we[c]             = we;
        in_data[c*32 +: 32]  = data;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        rob_head       = '0;
        mispredict     = 1'b0;
        mispredict_tag = '0;
        clear_in();
        #2;
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++; $display("FAIL reset_cdb_valid got=%b exp=00", cdb_valid);
        end
        total++;
        if (in_ready !== 3'b111) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=111", in_ready);
        end
        total++;
        if (cdb_data !== 64'h0) begin
            bad++; $display("FAIL reset_cdb_data got=%h exp=0", cdb_data);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        for (int rep = 0; rep < 2; rep++) begin
            set_ch(0, 5'd1, 7'd1, 1'b1, 32'h100);
            set_ch(1, 5'd2, 7'd2, 1'b1, 32'h200);
            set_ch(2, 5'd3, 7'd3, 1'b0, 32'h300);
            tick();
            clear_in();
            tick();
            total++;
            if (cdb_valid !== 2'b11 || cdb_rob_tag !== {5'd2, 5'd1} ||
                cdb_data !== {32'h200, 32'h100}) begin
                bad++;
                $display("FAIL contention_first rep=%0d got v=%b tag=%h data=%h exp v=11 tag=%h data=%h",
                         rep, cdb_valid, cdb_rob_tag, cdb_data, {5'd2, 5'd1}, {32'h200, 32'h100});
            end
            tick();
            total++;
            if (cdb_valid !== 2'b01 || cdb_rob_tag !== {5'd0, 5'd3} ||
                cdb_data !== {32'h0, 32'h300} || cdb_we !== 2'b00) begin
                bad++;
                $display("FAIL contention_second rep=%0d got v=%b tag=%h data=%h we=%b exp v=01 tag=%h data=%h we=00",
                         rep, cdb_valid, cdb_rob_tag, cdb_data, cdb_we, {5'd0, 5'd3}, {32'h0, 32'h300});
            end
            tick();
            total++;
            if (cdb_valid !== 2'b00) begin
                bad++; $display("FAIL contention_idle rep=%0d got=%b exp=00", rep, cdb_valid);
            end
        end
    endtask

    task automatic test_single();
        set_ch(0, 5'd3, 7'd10, 1'b1, 32'hDEADBEEF);
        tick();
        clear_in();
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++; $display("FAIL single_early got=%b exp=00", cdb_valid);
        end
        tick();
        total++;
        if (cdb_valid !== 2'b01 || cdb_rob_tag !== {5'd0, 5'd3} || cdb_pd !== {7'd0, 7'd10} ||
            cdb_we !== 2'b01 || cdb_data !== {32'h0, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_fields got v=%b tag=%h pd=%h we=%b data=%h exp v=01 tag=003 pd=000a we=01 data=00000000deadbeef",
                     cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data);
        end
        tick();
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++; $display("FAIL single_pulse got=%b exp=00", cdb_valid);
        end
    endtask

    task automatic test_backpressure();
        int unsigned seq_in [3];
        int unsigned seq_out [3];
        int          acc;
        int          bcast;
        bit          saw_low;
        logic [2:0]  accmask;
        logic [31:0] d;
        int unsigned ch;
        acc     = 0;
        bcast   = 0;
        saw_low = 1'b0;
        for (int c = 0; c < 3; c++) begin
            seq_in[c]  = 0;
            seq_out[c] = 0;
        end
        for (int cyc = 0; cyc < 28; cyc++) begin
            clear_in();
            if (cyc < 12) begin
                for (int c = 0; c < 3; c++) begin
                    set_ch(c, 5'(seq_in[c]), 7'(c), 1'b1, {8'(c), 24'(seq_in[c])});
                end
            end
            accmask = in_valid & in_ready;
            if (in_ready !== 3'b111) saw_low = 1'b1;
            tick();
            for (int c = 0; c < 3; c++) begin
                if (accmask[c]) begin
                    seq_in[c]++;
                    acc++;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (cdb_valid[p]) begin
                    d  = cdb_data[p*32 +: 32];
                    ch = 32'(d[31:24]);
                    bcast++;
                    total++;
                    if (ch > 2) begin
                        bad++; $display("FAIL bp_channel port=%0d got data=%h exp channel<3", p, d);
                    end else if (d[23:0] !== 24'(seq_out[ch])) begin
                        bad++;
                        $display("FAIL bp_order ch=%0d got seq=%0d exp seq=%0d", ch, d[23:0], seq_out[ch]);
                    end else begin
                        seq_out[ch]++;
                    end
                end
            end
        end
        clear_in();
        total++;
        if (saw_low !== 1'b1) begin
            bad++; $display("FAIL bp_ready_drop got=%0d exp=1", saw_low);
        end
        total++;
        if (acc !== bcast || acc < 24) begin
            bad++; $display("FAIL bp_count got accepted=%0d broadcast=%0d exp equal and >=24", acc, bcast);
        end
    endtask

    task automatic test_wrap_squash();
        bit seen;
        rob_head = 5'd30;
        set_ch(0, 5'd31, 7'd5, 1'b1, 32'hA);
        set_ch(1, 5'd1,  7'd6, 1'b1, 32'hB);
        set_ch(2, 5'd2,  7'd7, 1'b1, 32'hC);
        tick();
        clear_in();
        set_ch(0, 5'd5, 7'd8, 1'b1, 32'hD);
        mispredict     = 1'b1;
        mispredict_tag = 5'd0;
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL squash_in_ready got=%b exp=1", in_ready[0]);
        end
        tick();
        clear_in();
        mispredict = 1'b0;
        total++;
        if (cdb_valid !== 2'b01 || cdb_rob_tag[4:0] !== 5'd31 || cdb_data[31:0] !== 32'hA) begin
            bad++;
            $display("FAIL squash_survivor got v=%b tag=%0d data=%h exp v=01 tag=31 data=0000000a",
                     cdb_valid, cdb_rob_tag[4:0], cdb_data[31:0]);
        end
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (cdb_valid !== 2'b00) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL squash_leak got broadcast=%0d exp=0", seen);
        end
        // the branch's own tag survives, a younger one does not
        set_ch(0, 5'd0, 7'd9, 1'b1, 32'hE);
        set_ch(1, 5'd3, 7'd9, 1'b1, 32'hF);
        tick();
        clear_in();
        mispredict     = 1'b1;
        mispredict_tag = 5'd0;
        tick();
        mispredict = 1'b0;
        total++;
        if (cdb_valid !== 2'b01 || cdb_rob_tag[4:0] !== 5'd0 || cdb_data[31:0] !== 32'hE) begin
            bad++;
            $display("FAIL squash_own_tag got v=%b tag=%0d data=%h exp v=01 tag=0 data=0000000e",
                     cdb_valid, cdb_rob_tag[4:0], cdb_data[31:0]);
        end
        tick();
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++; $display("FAIL squash_younger_gone got=%b exp=00", cdb_valid);
        end
        rob_head = 5'd0;
    endtask

`ifdef WB_AGE_PRIO_EN
    task automatic test_age_prio();
        rob_head = 5'd1;
        set_ch(0, 5'd6, 7'd1, 1'b1, 32'h6);
        set_ch(1, 5'd2, 7'd2, 1'b1, 32'h2);
        set_ch(2, 5'd4, 7'd3, 1'b1, 32'h4);
        tick();
        clear_in();
        tick();
        total++;
        if (cdb_valid !== 2'b11 || cdb_rob_tag !== {5'd4, 5'd2}) begin
            bad++; $display("FAIL age_first got v=%b tag=%h exp v=11 tag=%h", cdb_valid, cdb_rob_tag, {5'd4, 5'd2});
        end
        tick();
        total++;
        if (cdb_valid !== 2'b01 || cdb_rob_tag !== {5'd0, 5'd6}) begin
            bad++; $display("FAIL age_second got v=%b tag=%h exp v=01 tag=%h", cdb_valid, cdb_rob_tag, {5'd0, 5'd6});
        end
        tick();
        rob_head = 5'd0;
    endtask
`endif

    task automatic test_mid_reset();
        bit seen;
        bit busy;
        busy = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            for (int c = 0; c < 3; c++) begin
                set_ch(c, 5'(cyc + 1), 7'(c), 1'b1, 32'(100 + cyc * 3 + c));
            end
            tick();
            if (cdb_valid !== 2'b00) busy = 1'b1;
        end
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_reset_traffic got busy=%0d exp=1", busy);
        end
        clear_in();
        reset = 1'b0;
        #1;
        total++;
        if (cdb_valid !== 2'b00 || cdb_data !== 64'h0) begin
            bad++; $display("FAIL mid_reset_cdb got v=%b data=%h exp v=00 data=0", cdb_valid, cdb_data);
        end
        total++;
        if (in_ready !== 3'b111) begin
            bad++; $display("FAIL mid_reset_ready got=%b exp=111", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            tick();
            if (cdb_valid !== 2'b00) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_reset_stale got broadcast=%0d exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_wrap_squash();
`ifdef WB_AGE_PRIO_EN
        test_age_prio();
`endif
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
